pwm_capture_16bits: RTL and testbench
=====================================

# pwm_capture_16bits

Measures period and active (high) time of an external PWM signal, such as a gate signal fed back from a converter leg or the output of another PWM block. It is the receive-side counterpart of the PWM generator. Measurements are in system-clock cycles. Each completed period produces a one-cycle valid strobe. The block sits beside the PWM generator in the PL fabric, and its outputs feed AXI-readable status registers and the interrupt logic.

## Interface
Parameters:
- `WIDTH`, 16: width of all counters and measurement outputs.
- `SYNC_STAGES`, 2: number of synchroniser flops on `pwm_in` (minimum 2).

Ports:
- `clk`, in, 1: system clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `enable`, in, 1: capture ON/OFF. Low forces IDLE.
- `pwm_in`, in, 1: asynchronous PWM input.
- `polarity`, in, 1: 0 means the active level is high; 1 means the active level is low. The block uses `act = sync(pwm_in) ^ polarity`.
- `timeout`, in, WIDTH: number of cycles without an active edge before a stall is declared. 0 disables the timeout.
- `period_out`, out, WIDTH: last measured period, in clk cycles.
- `high_out`, out, WIDTH: active-level time within the last period, in clk cycles.
- `meas_valid`, out, 1: one-cycle strobe when `period_out` and `high_out` update.
- `meas_ovf`, out, 1: the last measurement saturated. Updates together with `meas_valid`.
- `stall`, out, 1: sticky flag meaning no active edge arrived within `timeout`.

## Operation
- **Synchroniser:** a `SYNC_STAGES`-flop chain feeds `act`. `act_d` is `act` delayed by one register.
- **Active edge:** `edge = act & ~act_d`. Only active (rising) edges are detected.
- **States:**
  - IDLE: entered on reset or when `enable=0`.
  - ARM: waiting for the first edge.
  - MEAS: measuring.
- **Transitions:**
  - IDLE → ARM when `enable=1`.
  - ARM → MEAS on `edge`.
  - MEAS → MEAS on `edge`, which completes a measurement.
  - MEAS → ARM on timeout.
  - Any state → IDLE when `enable=0`. This has priority over all other conditions.
- **Counters:** `per_cnt` and `hi_cnt`, both WIDTH bits wide and saturating at all-ones. A per-measurement `sat` flag records any saturation of either counter.
- **ARM on `edge`:**
  - `per_cnt<=0`, `hi_cnt<=1`, `sat<=0`.
  - No strobe is issued, because the first period is incomplete.
- **MEAS on cycles without `edge`:**
  - `per_cnt` increments.
  - `hi_cnt` increments when `act=1`.
  - If either counter is already all-ones, it holds and `sat<=1`.
- **MEAS on `edge`:**
  - `period_out <= sat_add(per_cnt,1)`, `high_out <= hi_cnt`, `meas_ovf <= sat | (per_cnt==all-ones)`.
  - `meas_valid<=1`, `stall<=0`.
  - Counters restart: `per_cnt<=0`, `hi_cnt<=1`, `sat<=0`.
- **Timeout:**
  - In MEAS or ARM with `timeout!=0`, a separate `idle_cnt` counts cycles since the last edge or since entering ARM.
  - When `idle_cnt==timeout-1` and no edge arrives: `stall<=1` and the state goes to ARM.
  - `period_out`, `high_out` and `meas_ovf` hold their last values.
  - An `edge` in the same cycle as the timeout wins: the measurement is taken and there is no stall.
- **Arithmetic:** unsigned arithmetic throughout. `high_out <= period_out` always holds.
- **100 % duty:** no edge ever occurs, so the block ends in a timeout. 0 % duty behaves the same way.
- **`enable` falling mid-period:**
  - The partial period is discarded and all counters are cleared.
  - `stall` is cleared.
  - `period_out`, `high_out` and `meas_ovf` keep their last values.
  - The synchroniser keeps running.
- **`polarity` change:** takes effect immediately. Software changes it only while `enable=0`.

## Timing
- **Reset values:** state=IDLE; all counters 0; synchroniser 0; `period_out=0`, `high_out=0`, `meas_valid=0`, `meas_ovf=0`, `stall=0`.
- **Latency:** `meas_valid` is high in the cycle after the (`SYNC_STAGES`+1)-th rising clk edge, counting from the first edge that samples the new active level. With the default, that is 3 clk edges.
- **Strobe width:** `meas_valid` lasts exactly one cycle. There is no handshake; consumers sample on the strobe.
- **Minimum resolvable pulse:** active and inactive phases must each be at least 1 clk cycle. Shorter pulses may be missed.
- **Throughput:** one measurement per input period, with a minimum period of 2 cycles.
- **Timing closure:** outputs are registered and timing is closed at the system clock.

## Test plan
- **Steady PWM:** reset, `enable=1`, `polarity=0`, `timeout=0`, with `pwm_in` a period-100 / high-30 pulse train.
  - The first edge produces no strobe.
  - Every later edge produces `meas_valid` with `period_out=100`, `high_out=30`, `meas_ovf=0`.
- **Inverted polarity:** same stimulus with `polarity=1` → `period_out=100`, `high_out=70`.
- **Saturation:** WIDTH=8, period 300 / high 200 → `period_out=255`, `high_out=200`, `meas_ovf=1`. The next period of 100 reports `meas_ovf=0`.
- **Timeout:** `timeout=150`, period 100, then `pwm_in` held high.
  - `stall` rises exactly 150 cycles after the last edge.
  - Outputs hold `100/30` and no strobe is issued.
  - After the train resumes, `stall` clears on the second edge together with `meas_valid`.
- **Enable drop:** `enable` drops mid-period → IDLE on the next cycle with no strobe.
  - After `enable` is re-asserted, the first edge produces no strobe and the second edge reports the correct period.
- **Async reset mid-measurement:** all outputs read 0 immediately, without waiting for `clk`.
  - After reset release, behaviour matches the steady-PWM scenario.

Source files
------------

// File: rtl/pwm_capture_16bits_if.sv
// rtl/pwm_capture_16bits_if.sv - control inputs and measurement outputs of the PWM capture block
interface pwm_capture_16bits_if #(
  parameter int WIDTH = 16
);
  logic             enable;
  logic             pwm_in;
  logic             polarity;
  logic [WIDTH-1:0] timeout;
  logic [WIDTH-1:0] period_out;
  logic [WIDTH-1:0] high_out;
  logic             meas_valid;
  logic             meas_ovf;
  logic             stall;

  modport master (
    output enable, pwm_in, polarity, timeout,
    input  period_out, high_out, meas_valid, meas_ovf, stall
  );

  modport slave (
    input  enable, pwm_in, polarity, timeout,
    output period_out, high_out, meas_valid, meas_ovf, stall
  );
endinterface

// File: rtl/pwm_capture_16bits.sv
// rtl/pwm_capture_16bits.sv - measures period and active time of an external PWM input
module pwm_capture_16bits #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic                  clk,
  input logic                  reset,
  pwm_capture_16bits_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   act, act_d, act_edge;
  logic                   timeout_en, timed_out;
  logic [WIDTH-1:0]       timeout_m1;

  logic [WIDTH-1:0] per_cnt, per_n;
  logic [WIDTH-1:0] hi_cnt, hi_n;
  logic [WIDTH-1:0] idle_cnt, idle_n;
  logic             sat, sat_n;

  logic [WIDTH-1:0] period_q, period_n;
  logic [WIDTH-1:0] high_q, high_n;
  logic             ovf_q, ovf_n;
  logic             valid_q, valid_n;
  logic             stall_q, stall_n;

  // The synchroniser runs regardless of enable so act_d is settled on re-enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      act_d  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pwm_in};
      act_d  <= act;
    end
  end

  assign act        = sync_q[SYNC_STAGES-1] ^ bus.polarity;
  assign act_edge   = act & ~act_d;
  assign timeout_en = (bus.timeout != '0);
  assign timeout_m1 = bus.timeout - ONE;
  assign timed_out  = timeout_en && (idle_cnt == timeout_m1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      per_cnt  <= '0;
      hi_cnt   <= '0;
      idle_cnt <= '0;
      sat      <= 1'b0;
      period_q <= '0;
      high_q   <= '0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
      stall_q  <= 1'b0;
    end else begin
      state    <= state_n;
      per_cnt  <= per_n;
      hi_cnt   <= hi_n;
      idle_cnt <= idle_n;
      sat      <= sat_n;
      period_q <= period_n;
      high_q   <= high_n;
      ovf_q    <= ovf_n;
      valid_q  <= valid_n;
      stall_q  <= stall_n;
    end
  end

  always_comb begin
    state_n  = state;
    per_n    = per_cnt;
    hi_n     = hi_cnt;
    idle_n   = idle_cnt;
    sat_n    = sat;
    period_n = period_q;
    high_n   = high_q;
    ovf_n    = ovf_q;
    valid_n  = 1'b0;
    stall_n  = stall_q;

    if (!bus.enable) begin
      state_n = IDLE;
      per_n   = '0;
      hi_n    = '0;
      idle_n  = '0;
      sat_n   = 1'b0;
      stall_n = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state_n = ARM;
          idle_n  = '0;
        end
        ARM: begin
          if (act_edge) begin
            state_n = MEAS;
            per_n   = '0;
            hi_n    = ONE;
            sat_n   = 1'b0;
            idle_n  = '0;
          end else if (timed_out) begin
            stall_n = 1'b1;
            idle_n  = '0;
          end else if (timeout_en) begin
            idle_n = idle_cnt + ONE;
          end
        end
        MEAS: begin
          if (act_edge) begin
            // The edge cycle itself belongs to the closing period, hence the +1.
            period_n = (per_cnt == ALL_ONES) ? ALL_ONES : per_cnt + ONE;
            high_n   = hi_cnt;
            ovf_n    = sat | (per_cnt == ALL_ONES);
            valid_n  = 1'b1;
            stall_n  = 1'b0;
            per_n    = '0;
            hi_n     = ONE;
            sat_n    = 1'b0;
            idle_n   = '0;
          end else begin
            if (per_cnt == ALL_ONES) sat_n = 1'b1;
            else                     per_n = per_cnt + ONE;
            if (act) begin
              if (hi_cnt == ALL_ONES) sat_n = 1'b1;
              else                    hi_n  = hi_cnt + ONE;
            end
            if (timed_out) begin
              stall_n = 1'b1;
              state_n = ARM;
              idle_n  = '0;
            end else if (timeout_en) begin
              idle_n = idle_cnt + ONE;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign bus.period_out = period_q;
  assign bus.high_out   = high_q;
  assign bus.meas_ovf   = ovf_q;
  assign bus.meas_valid = valid_q;
  assign bus.stall      = stall_q;

endmodule

// File: tb/tb_pwm_capture_16bits.sv
// tb/tb_pwm_capture_16bits.sv - bench for pwm_capture_16bits with 16-bit and 8-bit instances
module tb_pwm_capture_16bits;
  localparam int SYNC = 2;
  localparam int MAXC = 65536;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  bit          en = 1'b0;
  bit          pwm = 1'b0;
  bit          pol = 1'b0;
  logic [15:0] tmo = '0;

  int checks = 0;
  int failures = 0;

  pwm_capture_16bits_if #(.WIDTH(16)) if16 ();
  pwm_capture_16bits_if #(.WIDTH(8))  if8 ();

  assign if16.enable   = en;
  assign if16.pwm_in   = pwm;
  assign if16.polarity = pol;
  assign if16.timeout  = tmo;
  assign if8.enable    = en;
  assign if8.pwm_in    = pwm;
  assign if8.polarity  = pol;
  assign if8.timeout   = tmo[7:0];

  pwm_capture_16bits #(.WIDTH(16), .SYNC_STAGES(SYNC)) dut16 (.clk(clk), .reset(reset), .bus(if16));
  pwm_capture_16bits #(.WIDTH(8),  .SYNC_STAGES(SYNC)) dut8  (.clk(clk), .reset(reset), .bus(if8));

  always #5 clk = ~clk;

  // Reference model: per-cycle act history, measurements from edge timestamps.
  int cyc = 0;
  int rstart = 0;
  bit prev_act = 1'b0;
  bit pwm_hist [MAXC];
  bit act_hist [MAXC];
  int maxv   [2] = '{65535, 255};
  int mode   [2];
  int ref_c  [2];
  int last_e [2];
  int e_per  [2];
  int e_hi   [2];
  bit e_val  [2];
  bit e_ovf  [2];
  bit e_stall[2];

  task automatic model_step(input int w, input bit e, input int n);
    int p, h;
    e_val[w] = 1'b0;
    if (!en) begin
      mode[w] = 0;
      e_stall[w] = 1'b0;
    end else if (mode[w] == 0) begin
      mode[w] = 1;
      ref_c[w] = n;
    end else if (e) begin
      if (mode[w] == 2) begin
        p = n - last_e[w];
        h = 0;
        for (int k = last_e[w]; k < n; k++) h += int'(act_hist[k]);
        e_per[w]   = (p > maxv[w]) ? maxv[w] : p;
        e_hi[w]    = (h > maxv[w]) ? maxv[w] : h;
        e_ovf[w]   = (p > maxv[w]);
        e_val[w]   = 1'b1;
        e_stall[w] = 1'b0;
      end
      mode[w] = 2;
      last_e[w] = n;
      ref_c[w] = n;
    end else if (tmo != 0 && (n - ref_c[w]) == int'(tmo)) begin
      e_stall[w] = 1'b1;
      mode[w] = 1;
      ref_c[w] = n;
    end
  endtask

  initial begin
    bit a, e;
    forever begin
      @(posedge clk);
      cyc++;
      if (cyc >= MAXC) begin
        $display("FAIL cycle_budget got=%0d want<%0d", cyc, MAXC);
        $fatal(1, "cycle budget exhausted");
      end
      if (reset) begin
        rstart = cyc + 1;
        prev_act = 1'b0;
        for (int w = 0; w < 2; w++) begin
          mode[w] = 0; e_per[w] = 0; e_hi[w] = 0;
          e_val[w] = 1'b0; e_ovf[w] = 1'b0; e_stall[w] = 1'b0;
        end
      end else begin
        pwm_hist[cyc] = pwm;
        a = ((cyc - SYNC >= rstart) ? pwm_hist[cyc-SYNC] : 1'b0) ^ pol;
        act_hist[cyc] = a;
        e = a & ~prev_act;
        prev_act = a;
        for (int w = 0; w < 2; w++) model_step(w, e, cyc);
      end
    end
  end

  task automatic check_dut(input string name, input int w, input int per, input int hi,
                           input logic v, input logic o, input logic s);
    checks++;
    if (per !== e_per[w] || hi !== e_hi[w] || v !== e_val[w] || o !== e_ovf[w] || s !== e_stall[w]) begin
      failures++;
      $display("FAIL %s cyc=%0d got per=%0d hi=%0d v=%b ovf=%b stall=%b want per=%0d hi=%0d v=%b ovf=%b stall=%b",
               name, cyc, per, hi, v, o, s, e_per[w], e_hi[w], e_val[w], e_ovf[w], e_stall[w]);
    end
  endtask

  task automatic expect_eq(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Strobe monitor feeding the literal checks.
  int n16 = 0, n8 = 0;
  int last_per16 = 0, last_hi16 = 0, last_ovf16 = 0;
  int last_per8 = 0, last_hi8 = 0, last_ovf8 = 0;
  int strobe_cyc16 = 0, stall_rise_cyc = -1;
  bit prev_stall16 = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        check_dut("model_u16", 0, int'(if16.period_out), int'(if16.high_out),
                  if16.meas_valid, if16.meas_ovf, if16.stall);
        check_dut("model_u8", 1, int'(if8.period_out), int'(if8.high_out),
                  if8.meas_valid, if8.meas_ovf, if8.stall);
        if (if16.meas_valid) begin
          n16++;
          last_per16 = int'(if16.period_out);
          last_hi16  = int'(if16.high_out);
          last_ovf16 = int'(if16.meas_ovf);
          strobe_cyc16 = cyc;
        end
        if (if8.meas_valid) begin
          n8++;
          last_per8 = int'(if8.period_out);
          last_hi8  = int'(if8.high_out);
          last_ovf8 = int'(if8.meas_ovf);
        end
        if (if16.stall && !prev_stall16 && stall_rise_cyc < 0) stall_rise_cyc = cyc;
        prev_stall16 = if16.stall;
      end
    end
  end

  task automatic drive(input bit lvl, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pwm = lvl;
    end
  endtask

  task automatic pulse(input int h, input int l);
    drive(1'b1, h);
    drive(1'b0, l);
  endtask

  task automatic start_phase(input bit p, input int t);
    @(negedge clk);
    en = 1'b0;
    pwm = 1'b0;
    repeat (4) @(negedge clk);
    pol = p;
    tmo = 16'(t);
    repeat (4) @(negedge clk);
    n16 = 0;
    n8 = 0;
    stall_rise_cyc = -1;
    en = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int sel, h, l;
    repeat (2) @(negedge clk);
    expect_eq("rst_period", int'(if16.period_out), 0);
    expect_eq("rst_high", int'(if16.high_out), 0);
    expect_eq("rst_valid", int'(if16.meas_valid), 0);
    expect_eq("rst_ovf", int'(if16.meas_ovf), 0);
    expect_eq("rst_stall", int'(if16.stall), 0);
    #2 reset = 1'b0;

    // Steady PWM, active high.
    start_phase(1'b0, 0);
    repeat (6) pulse(30, 70);
    expect_eq("steady_count", n16, 5);
    expect_eq("steady_period", last_per16, 100);
    expect_eq("steady_high", last_hi16, 30);
    expect_eq("steady_ovf", last_ovf16, 0);

    // Inverted polarity.
    start_phase(1'b1, 0);
    repeat (6) pulse(30, 70);
    expect_eq("inv_count", n16, 5);
    expect_eq("inv_period", last_per16, 100);
    expect_eq("inv_high", last_hi16, 70);

    // Saturation on the 8-bit instance.
    start_phase(1'b0, 0);
    repeat (3) pulse(200, 100);
    drive(1'b1, 5);
    expect_eq("sat_count_u8", n8, 3);
    expect_eq("sat_period_u8", last_per8, 255);
    expect_eq("sat_high_u8", last_hi8, 200);
    expect_eq("sat_ovf_u8", last_ovf8, 1);
    expect_eq("sat_period_u16", last_per16, 300);
    expect_eq("sat_ovf_u16", last_ovf16, 0);
    drive(1'b1, 25);
    drive(1'b0, 70);
    drive(1'b1, 5);
    expect_eq("unsat_period_u8", last_per8, 100);
    expect_eq("unsat_high_u8", last_hi8, 30);
    expect_eq("unsat_ovf_u8", last_ovf8, 0);

    // Timeout, then recovery.
    start_phase(1'b0, 150);
    repeat (4) pulse(30, 70);
    drive(1'b1, 400);
    expect_eq("to_stall", int'(if16.stall), 1);
    expect_eq("to_delay", stall_rise_cyc - strobe_cyc16, 150);
    expect_eq("to_count", n16, 4);
    expect_eq("to_period_hold", int'(if16.period_out), 100);
    expect_eq("to_high_hold", int'(if16.high_out), 30);
    drive(1'b0, 70);
    drive(1'b1, 5);
    expect_eq("to_first_edge_stall", int'(if16.stall), 1);
    expect_eq("to_first_edge_count", n16, 4);
    drive(1'b1, 25);
    drive(1'b0, 70);
    drive(1'b1, 5);
    expect_eq("to_second_edge_stall", int'(if16.stall), 0);
    expect_eq("to_second_edge_count", n16, 5);
    expect_eq("to_second_edge_period", last_per16, 100);

    // Enable dropped mid-period.
    start_phase(1'b0, 0);
    repeat (2) pulse(30, 70);
    drive(1'b1, 30);
    drive(1'b0, 20);
    en = 1'b0;
    drive(1'b0, 10);
    expect_eq("drop_count", n16, 2);
    en = 1'b1;
    drive(1'b0, 10);
    repeat (3) pulse(30, 70);
    expect_eq("reen_count", n16, 4);
    expect_eq("reen_period", last_per16, 100);
    expect_eq("reen_high", last_hi16, 30);

    // Asynchronous reset mid-measurement.
    start_phase(1'b0, 0);
    repeat (3) pulse(30, 70);
    drive(1'b1, 10);
    @(posedge clk);
    #3;
    reset = 1'b1;
    pwm = 1'b0;
    #1;
    expect_eq("arst_period", int'(if16.period_out), 0);
    expect_eq("arst_high", int'(if16.high_out), 0);
    expect_eq("arst_stall", int'(if16.stall), 0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    n16 = 0;
    drive(1'b0, 50);
    repeat (6) pulse(30, 70);
    expect_eq("arst_steady_count", n16, 5);
    expect_eq("arst_steady_period", last_per16, 100);
    expect_eq("arst_steady_high", last_hi16, 30);

    // Randomized trains with occasional enable drops.
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 5) == 0) begin
        @(negedge clk);
        en = 1'b0;
        pol = bit'($urandom_range(0, 1));
        tmo = ($urandom_range(0, 1) == 0) ? 16'd0 : 16'($urandom_range(20, 255));
        repeat ($urandom_range(2, 6)) @(negedge clk);
        en = 1'b1;
      end else begin
        sel = $urandom_range(0, 3);
        if (sel == 0) begin
          h = $urandom_range(1, 4); l = $urandom_range(1, 4);
        end else if (sel == 3) begin
          h = $urandom_range(150, 400); l = $urandom_range(50, 300);
        end else begin
          h = $urandom_range(10, 200); l = $urandom_range(10, 200);
        end
        pulse(h, l);
      end
    end
    repeat (10) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
